// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch controller for the 16-bit pipeline.
//
// Owns the program counter. It presents pc to the byte-addressed instruction
// memory and receives the instruction back as four nibbles: {one, two} from
// byte pc and {three, four} from byte pc+1. Fetched instructions go into the
// IF/ID pipeline register. The controller also handles stall, branch
// redirect, flush and the halt at the end of memory.
//
// Parameters
//   PC_W      width of pc and of the memory address
//   MEM_LAST  highest valid byte index of instruction memory
//   RESET_PC  pc after reset (must be even)
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous, active-low reset
//   stall        hold pc and the IF/ID contents
//   br_taken     redirect pc to br_target (bit 0 forced to 0)
//   br_target    redirect address
//   flush        squash the IF/ID entry on this edge
//   one..four    instruction nibbles [15:12], [11:8], [7:4], [3:0]
//   pc           fetch address to instruction memory
//   if_id_inst   latched instruction
//   if_id_pc     address of the latched instruction
//   if_id_valid  IF/ID entry holds a live instruction
//   halted       fetch stopped at end of memory

module fetch_unit #(
    parameter int unsigned     PC_W     = 16,
    parameter int unsigned     MEM_LAST = 22,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            flush,
    input  logic [3:0]      one,
    input  logic [3:0]      two,
    input  logic [3:0]      three,
    input  logic [3:0]      four,
    output logic [PC_W-1:0] pc,
    output logic [15:0]     if_id_inst,
    output logic [PC_W-1:0] if_id_pc,
    output logic            if_id_valid,
    output logic            halted
);

    typedef enum logic [1:0] {
        StFill,
        StRun,
        StHalt
    } state_e;

    // Range check is one bit wider than pc so that pc+1 can never wrap.
    localparam logic [PC_W:0] MemLast = (PC_W+1)'(MEM_LAST);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     inst_q, inst_d;
    logic [PC_W-1:0] ipc_q, ipc_d;
    logic            valid_q, valid_d;
    logic            halted_q, halted_d;

    logic [PC_W-1:0] redirect_pc;
    logic [PC_W:0]   pc_plus1_wide;
    logic            fetch_in_range;
    logic [15:0]     fetched_inst;

    // Instructions are 2-byte aligned, so the target's lsb is dropped.
    assign redirect_pc = {br_target[PC_W-1:1], 1'b0};

    logic unused_br_lsb;
    assign unused_br_lsb = br_target[0];

    assign pc_plus1_wide  = {1'b0, pc_q} + {{PC_W{1'b0}}, 1'b1};
    assign fetch_in_range = (pc_plus1_wide <= MemLast);
    assign fetched_inst   = {one, two, three, four};

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        ipc_d    = ipc_q;
        valid_d  = valid_q;
        halted_d = halted_q;

        unique case (state_q)
            // First edge after reset is a bubble. The memory read for RESET_PC
            // is only just being presented.
            StFill: begin
                valid_d = 1'b0;
                state_d = StRun;
                if (br_taken) begin
                    pc_d = redirect_pc;
                end
            end

            StRun: begin
                if (br_taken) begin
                    // The redirect wins even over stall. The instruction being
                    // fetched is on the wrong path, so the slot goes empty.
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                end else if (stall) begin
                    // Hold everything.
                end else if (fetch_in_range) begin
                    inst_d  = fetched_inst;
                    ipc_d   = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + PC_W'(2);
                end else begin
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
                    state_d  = StHalt;
                end
            end

            StHalt: begin
                valid_d  = 1'b0;
                halted_d = 1'b1;
                if (br_taken) begin
                    pc_d     = redirect_pc;
                    halted_d = 1'b0;
                    state_d  = StRun;
                end
            end

            default: begin
                state_d  = StFill;
                pc_d     = RESET_PC;
                valid_d  = 1'b0;
                halted_d = 1'b0;
            end
        endcase

        // flush only kills the valid bit. On an advance, the instruction and
        // its pc are still captured.
        if (flush) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StFill;
            pc_q     <= RESET_PC;
            inst_q   <= '0;
            ipc_q    <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            ipc_q    <= ipc_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    assign pc          = pc_q;
    assign if_id_inst  = inst_q;
    assign if_id_pc    = ipc_q;
    assign if_id_valid = valid_q;
    assign halted      = halted_q;

endmodule
